two_of_five_tx: RTL
===================

Name: two_of_five_tx

Overview:
- Encoder and transmitter for the 2-out-of-5 digit code used by the display path.
- Accepts BCD digits over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each digit to a 5-bit codeword {a,b,c,d,e}.
- Presents the latest codeword in parallel with a valid flag for the 7-segment decoder, and shifts each codeword out serially with a frame strobe.

Parameters:
- DEPTH, 4: FIFO depth in digits; power of two, minimum 2.
- GAP, 1: idle cycles forced between consecutive serial frames; 0 allowed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- din  input  4  BCD digit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept a digit; equals !full, independent of din_valid.
- a, b, c, d, e  output  1 each  parallel codeword of the most recently loaded digit.
- v  output  1  parallel codeword valid.
- tx_bit  output  1  serial data; a first, e last.
- tx_frame  output  1  high for exactly the 5 cycles a codeword is on tx_bit.
- busy  output  1  high when the FIFO is non-empty or the state is not IDLE.
- err  output  1  one-cycle pulse: an invalid digit was consumed.
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Codeword table, digit -> abcde:
  - 0=00110, 1=10001, 2=01001, 3=11000, 4=00101
  - 5=10100, 6=01100, 7=00011, 8=10010, 9=01010
  - Every codeword has exactly two ones.
- Handshake: a transfer occurs on the rising edge where din_valid && din_ready.
  - din 0..9: written to the FIFO.
  - din 10..15: consumed but not written; err=1 for the following cycle only.
- Full FIFO: din_ready=0 and no write occurs, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO: both occur; fifo_count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- State machine: IDLE, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty, pop the head, encode it, load the 5-bit shift register and a..e, set v=1, clear bit counter, go to SHIFT. Otherwise stay.
  - SHIFT: tx_frame=1 and tx_bit=shift register MSB. Shift left each cycle. After the 5th bit, go to GAP if GAP>0, else IDLE.
  - GAP: tx_frame=0 and tx_bit=0 for GAP cycles, then go to IDLE.
- Latency: an accepted digit reaching an empty FIFO in IDLE at edge k has a..e and v updated at edge k+1. tx_frame rises at edge k+1 and falls at edge k+6.
- Back-to-back throughput: one frame per 5+GAP+1 cycles (IDLE occupies one cycle).
- Parallel outputs: a..e and v change only on a load. They hold the last codeword between and after frames.
- Reset (rst_n=0 at a rising edge), including mid-frame, clears at that edge:
  - FIFO emptied; fifo_count=0.
  - State=IDLE.
  - a..e=0, v=0 (the display blanks).
  - tx_bit=0, tx_frame=0, err=0, busy=0.
  - din_ready=1 from the cycle after reset.
- All outputs are registered except din_ready and busy, which are combinational from registered state.

Optional Feature:
- Macro: TWO_OF_FIVE_TX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt, 8 bits, reset 0.
  - err_cnt increments on every consumed invalid digit and saturates at 255.
  - err_cnt is cleared only by reset.
- When undefined: the port does not exist; err behaviour is unchanged.

Test Plan:
- Reset, then push digit 3 once:
  - Next edge: abcde=11000, v=1, tx_frame high for 5 cycles.
  - tx_bit sequence 1,1,0,0,0.
  - busy drops after GAP+1 idle cycles.
- Push 0..9 back-to-back with DEPTH=4:
  - din_ready deasserts when fifo_count=4.
  - All ten codewords emerge serially in order, matching the table.
  - Every frame has exactly two 1 bits; frame spacing is 5+GAP+1 cycles.
- Push din=12 between digits 5 and 7:
  - err pulses for exactly one cycle.
  - Serial output is only 10100 then 00011; fifo_count never counts the 12.
- Assert rst_n=0 during the 3rd bit of a frame for digit 8:
  - Next edge: tx_frame=0, v=0, abcde=00000, fifo_count=0.
  - No residual bits after reset releases.
- Hold FIFO at count 3, present din_valid while a pop occurs:
  - Count stays 3; order is preserved.
  - With the FIFO full and a pop, din_ready=0 and the write is refused.
- With TWO_OF_FIVE_TX_ERR_CNT_EN, push 300 invalid digits:
  - err_cnt=255 and holds.
  - Reset returns err_cnt to 0.

Source files
------------

// File: rtl/two_of_five_tx.sv
// two_of_five_tx: BCD digit FIFO, 2-of-5 encoder, serial shifter.
// Ports: clk, rst_n (sync, active low); din/din_valid/din_ready input
//   handshake; a..e/v parallel codeword; tx_bit/tx_frame serial out;
//   busy, err (invalid digit pulse), fifo_count occupancy.
// Optional: TWO_OF_FIVE_TX_ERR_CNT_EN adds err_cnt[7:0], saturating.
module two_of_five_tx #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   e,
  output logic                   v,
  output logic                   tx_bit,
  output logic                   tx_frame,
  output logic                   busy,
  output logic                   err,
`ifdef TWO_OF_FIVE_TX_ERR_CNT_EN
  output logic [7:0]             err_cnt,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [4:0]    sreg;
  logic [2:0]    bcnt;
  logic [GW-1:0] gcnt;
  logic [4:0]    hcode;
  logic          full;
  logic          empty;
  logic          take;
  logic          bad;
  logic          push;
  logic          pop;

  function automatic logic [4:0] enc(input logic [3:0] dg);
    logic [4:0] r;
    case (dg)
      4'd0:    r = 5'b00110;
      4'd1:    r = 5'b10001;
      4'd2:    r = 5'b01001;
      4'd3:    r = 5'b11000;
      4'd4:    r = 5'b00101;
      4'd5:    r = 5'b10100;
      4'd6:    r = 5'b01100;
      4'd7:    r = 5'b00011;
      4'd8:    r = 5'b10010;
      4'd9:    r = 5'b01010;
      default: r = 5'b00000;
    endcase
    return r;
  endfunction

  assign full       = (cnt == (AW+1)'(DEPTH));
  assign empty      = (cnt == '0);
  assign din_ready  = !full;
  assign take       = din_valid && din_ready;
  assign bad        = (din > 4'd9);
  assign push       = take && !bad;
  assign pop        = (state == S_IDLE) && !empty;
  assign busy       = !empty || (state != S_IDLE);
  assign fifo_count = cnt;
  assign hcode      = enc(mem[rp]);

  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= wp + AW'(1);
      if (pop)
        rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      {a, b, c, d, e} <= 5'b0;
      v        <= 1'b0;
      tx_bit   <= 1'b0;
      tx_frame <= 1'b0;
      sreg     <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      err      <= 1'b0;
    end else begin
      err <= take && bad;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            {a, b, c, d, e} <= hcode;
            v        <= 1'b1;
            tx_bit   <= hcode[4];
            tx_frame <= 1'b1;
            sreg     <= {hcode[3:0], 1'b0};
            bcnt     <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bcnt == 3'd4) begin
            tx_frame <= 1'b0;
            tx_bit   <= 1'b0;
            gcnt     <= '0;
            state    <= (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            tx_bit <= sreg[4];
            sreg   <= {sreg[3:0], 1'b0};
            bcnt   <= bcnt + 3'd1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP - 1))
            state <= S_IDLE;
          else
            gcnt <= gcnt + GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TWO_OF_FIVE_TX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (take && bad && err_cnt != 8'hff)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
